// File: rtl/c432_key_loader_pkg.sv
// c432_lock_pkg: shared types and helpers for the c432 key loader.
package c432_lock_pkg;
    localparam int KEY_W_DEF = 16;

    typedef enum logic [2:0] {IDLE, SHIFT, CHECK, LOADED, ERROR, LOCKOUT} state_t;

    function automatic logic parity(input logic [31:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/c432_key_loader_shreg.sv
// c432_key_shreg: serial key capture register with bit counter and separate parity flop.
module c432_key_shreg #(
    parameter int KEY_W = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             din,
    output logic [KEY_W-1:0] data,
    output logic             par,
    output logic             last
);
    logic [CNT_W-1:0] cnt;
    assign last = cnt == CNT_W'(KEY_W);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            par  <= 1'b0;
            cnt  <= '0;
        end else if (clr) begin
            data <= '0;
            par  <= 1'b0;
            cnt  <= '0;
        end else if (shift_en) begin
            if (last) par <= din;
            else data <= data | (KEY_W'(din) << cnt);
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/c432_key_loader.sv
// c432_key_loader: serial key load, parity check and failure lockout for the locked c432 core.
module c432_key_loader
    import c432_lock_pkg::*;
#(
    parameter int KEY_W    = KEY_W_DEF,
    parameter int MAX_FAIL = 3,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             zeroize,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic             ser_ready,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             load_err,
    output logic             locked_out,
    output logic [3:0]       fail_cnt
);
    state_t           state;
    logic [KEY_W-1:0] data;
    logic             par, last, ok, xfer, clr, zero;
    logic [3:0]       nxt_fail;

    assign zero     = zeroize && state != LOCKOUT;
    assign xfer     = ser_valid && ser_ready && !zero;
    assign clr      = start && !zero && (state == IDLE || state == LOADED || state == ERROR);
    assign ok       = (parity(32'(data)) ^ par) == 1'b0;
    assign nxt_fail = fail_cnt == 4'(MAX_FAIL) ? fail_cnt : fail_cnt + 1'b1;
    assign load_err = state == CHECK && !ok;

    c432_key_shreg #(.KEY_W(KEY_W), .CNT_W(CNT_W)) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .shift_en (xfer),
        .din      (ser_in),
        .data     (data),
        .par      (par),
        .last     (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            key        <= '0;
            key_valid  <= 1'b0;
            ser_ready  <= 1'b0;
            locked_out <= 1'b0;
            fail_cnt   <= '0;
        end else if (zero) begin
            state     <= IDLE;
            key       <= '0;
            key_valid <= 1'b0;
            ser_ready <= 1'b0;
        end else begin
            case (state)
                IDLE, LOADED, ERROR: begin
                    if (start) begin
                        state     <= SHIFT;
                        ser_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (xfer && last) begin
                        state     <= CHECK;
                        ser_ready <= 1'b0;
                    end
                end
                CHECK: begin
                    if (ok) begin
                        key       <= data;
                        key_valid <= 1'b1;
                        fail_cnt  <= '0;
                        state     <= LOADED;
                    end else begin
                        fail_cnt   <= nxt_fail;
                        locked_out <= nxt_fail == 4'(MAX_FAIL);
                        state      <= nxt_fail == 4'(MAX_FAIL) ? LOCKOUT : ERROR;
                    end
                end
                LOCKOUT: begin
                    key        <= '0;
                    key_valid  <= 1'b0;
                    ser_ready  <= 1'b0;
                    locked_out <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_c432_key_loader.sv
// tb_c432_key_loader: scoreboard bench for the c432 key loader.
module tb_c432_key_loader;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, zeroize = 1'b0, ser_in = 1'b0, ser_valid = 1'b0;
    logic        ser_ready, key_valid, load_err, locked_out;
    logic [15:0] key;
    logic [3:0]  fail_cnt;
    int          checks = 0, errors = 0;

    typedef struct {
        logic [15:0] pre_key;
        logic        pre_kv;
        logic        err;
        logic [15:0] k;
        logic        kv;
        logic [3:0]  fc;
        logic        lk;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic        prev = 1'b0;
    logic [15:0] m_key = '0;
    logic        m_kv = 1'b0;
    logic [3:0]  m_fc = '0;

    c432_key_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .zeroize    (zeroize),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .key        (key),
        .key_valid  (key_valid),
        .load_err   (load_err),
        .locked_out (locked_out),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_key"}, 32'(key), 0);
        chk({nm, "_key_valid"}, 32'(key_valid), 0);
        chk({nm, "_ser_ready"}, 32'(ser_ready), 0);
        chk({nm, "_load_err"}, 32'(load_err), 0);
        chk({nm, "_locked_out"}, 32'(locked_out), 0);
        chk({nm, "_fail_cnt"}, 32'(fail_cnt), 0);
    endtask

    task automatic load_key(input logic [15:0] k, input logic pbit, input int stall_at, input int zero_at);
        exp_t ne;
        ne.pre_key = m_key;
        ne.pre_kv  = m_kv;
        if (zero_at >= 0) begin
            ne.pre_key = '0;
            ne.pre_kv  = 1'b0;
            ne.err     = 1'b0;
            ne.k       = '0;
            ne.kv      = 1'b0;
            ne.fc      = m_fc;
            ne.lk      = 1'b0;
            m_key      = '0;
            m_kv       = 1'b0;
        end else if (((^k) ^ pbit) == 1'b0) begin
            ne.err = 1'b0;
            m_key  = k;
            m_kv   = 1'b1;
            m_fc   = '0;
            ne.k   = k;
            ne.kv  = 1'b1;
            ne.fc  = '0;
            ne.lk  = 1'b0;
        end else begin
            ne.err = 1'b1;
            m_fc   = m_fc + 1'b1;
            ne.k   = m_key;
            ne.kv  = m_kv;
            ne.fc  = m_fc;
            ne.lk  = m_fc == 4'd3;
        end
        exp_q.push_back(ne);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i == stall_at) begin
                ser_valid = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("ready_during_stall", 32'(ser_ready), 1);
                    @(posedge clk); #1;
                end
            end
            ser_valid = 1'b1;
            ser_in    = i < 16 ? k[i] : pbit;
            if (i == zero_at) zeroize = 1'b1;
            @(posedge clk); #1;
            zeroize = 1'b0;
            if (i == zero_at) begin
                ser_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                return;
            end
        end
        ser_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: a falling ser_ready marks either CHECK or a zeroize; compare then and one cycle later.
    initial forever begin
        @(negedge clk);
        if (rst) prev = 1'b0;
        else begin
            if (prev && !ser_ready) begin
                if (exp_q.size() == 0) chk("unexpected_event", 32'(ser_ready), 1);
                else begin
                    e = exp_q.pop_front();
                    chk("pre_key", 32'(key), 32'(e.pre_key));
                    chk("pre_key_valid", 32'(key_valid), 32'(e.pre_kv));
                    chk("load_err", 32'(load_err), 32'(e.err));
                    @(negedge clk);
                    chk("key", 32'(key), 32'(e.k));
                    chk("key_valid", 32'(key_valid), 32'(e.kv));
                    chk("fail_cnt", 32'(fail_cnt), 32'(e.fc));
                    chk("locked_out", 32'(locked_out), 32'(e.lk));
                    chk("load_err_pulse", 32'(load_err), 0);
                end
            end
            prev = ser_ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

    initial begin
        #2;
        chk_reset("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        load_key(16'hA5C3, 1'b0, -1, -1);
        chk("p1", 32'(key[0]), 1);
        chk("p2", 32'(key[1]), 1);
        chk("p16", 32'(key[15]), 1);
        load_key(16'hA5C3, 1'b0, 8, -1);
        load_key(16'h00FF, 1'b0, -1, -1);
        load_key(16'h1234, 1'b0, -1, -1);
        chk("bad_keeps_key", 32'(key), 32'h00FF);
        load_key(16'h1234, 1'b0, -1, -1);
        load_key(16'h1234, 1'b0, -1, -1);
        chk("lock_key", 32'(key), 0);
        chk("lock_key_valid", 32'(key_valid), 0);
        chk("lock_sticky", 32'(locked_out), 1);
        start = 1'b1;
        zeroize = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        zeroize = 1'b0;
        @(negedge clk);
        chk("lock_ignores_start", 32'(ser_ready), 0);
        chk("lock_ignores_zeroize", 32'(locked_out), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        chk_reset("after_lock_reset");
        m_key = '0;
        m_kv  = 1'b0;
        m_fc  = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        load_key(16'h00FF, 1'b0, -1, -1);
        load_key(16'hA5C3, 1'b0, -1, 9);
        load_key(16'hFFFF, 1'b0, -1, -1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ser_valid = 1'b1;
        ser_in = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        ser_valid = 1'b0;
        #1;
        chk_reset("async_reset");
        m_key = '0;
        m_kv  = 1'b0;
        m_fc  = '0;
        #4;
        rst = 1'b0;
        @(posedge clk); #1;
        load_key(16'h8001, 1'b0, -1, -1);
        chk("final_key", 32'(key), 32'h8001);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
